// File: rtl/ederah_ctrl_pkg.sv
// Shared types and helpers for the EDERAH kernel control sequencer.
// Holds the FSM state encoding and the cache-line to byte conversion.
package ederah_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        RUN,
        DONE
    } ctrl_state_t;

    localparam int CL_BYTES_LOG2 = 6;
    localparam int MAX_XFER_W    = 64;

    // Callers truncate the result to their own size width.
    function automatic logic [MAX_XFER_W-1:0] cls_to_bytes(
        input logic [MAX_XFER_W-1:0] cls
    );
        return cls << CL_BYTES_LOG2;
    endfunction

endpackage

// File: rtl/ederah_ctrl_chan_tracker.sv
// Per-channel tracker: pending bit plus optional cycle counter.
// Counter logic exists only when EDERAH_CTRL_STATS_EN is defined.
module ederah_ctrl_chan_tracker
    import ederah_ctrl_pkg::*;
#(
    parameter int C_CNT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic                   run_i,
    input  logic                   done_i,
    output logic                   pending_o,
    output logic                   pending_run_o,
    output logic [C_CNT_WIDTH-1:0] cycles_o
);

    logic pending_q;
    logic pending_d;
    logic accept;

    // A done only counts while running and still pending.
    assign accept        = run_i & done_i & pending_q;
    assign pending_run_o = pending_q & ~accept;
    assign pending_o     = pending_q;

    // Pending next-state: clear on latch, arm on start, drop on accept.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end else if (load_i) begin
            pending_d = en_i;
        end else if (accept) begin
            pending_d = 1'b0;
        end
    end

    // Pending register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef EDERAH_CTRL_STATS_EN
    logic [C_CNT_WIDTH-1:0] cnt_q;
    logic [C_CNT_WIDTH-1:0] cnt_d;

    // Count RUN cycles while pending, including the accepting cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i && pending_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + C_CNT_WIDTH'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycles_o = cnt_q;
`else
    assign cycles_o = '0;
`endif

endmodule

// File: rtl/ederah_kernel_ctrl.sv
// Kernel control sequencer: ap_start edge -> one multi-channel run.
// Optional per-channel statistics under EDERAH_CTRL_STATS_EN.
module ederah_kernel_ctrl
    import ederah_ctrl_pkg::*;
#(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_CNT_WIDTH       = 32
) (
    input  logic                                        data_clk,
    input  logic                                        data_rst_n,
    input  logic                                        ap_start,
    output logic                                        ap_idle,
    output logic                                        ap_done,
    input  logic [C_NUM_CHANNELS-1:0]                   ch_enable_i,
    input  logic [C_NUM_CHANNELS*C_XFER_SIZE_WIDTH-1:0] xfer_cls_i,
    input  logic [C_CNT_WIDTH-1:0]                      timeout_cycles_i,
    output logic [C_NUM_CHANNELS*C_XFER_SIZE_WIDTH-1:0] ch_xfer_bytes_o,
    output logic [C_NUM_CHANNELS-1:0]                   ch_start_o,
    input  logic [C_NUM_CHANNELS-1:0]                   ch_done_i,
    output logic                                        timeout_o,
    output logic [C_NUM_CHANNELS-1:0]                   pending_o,
    output logic [C_NUM_CHANNELS*C_CNT_WIDTH-1:0]       ch_cycles_o
);

    localparam int N  = C_NUM_CHANNELS;
    localparam int W  = C_XFER_SIZE_WIDTH;
    localparam int CW = C_CNT_WIDTH;

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    logic          ap_start_r_q;
    logic          start_pulse;
    logic [N-1:0]  mask_q;
    logic [N-1:0]  mask_d;
    logic [N*W-1:0] bytes_q;
    logic [N*W-1:0] bytes_d;
    logic [CW-1:0] wd_q;
    logic [CW-1:0] wd_d;
    logic          to_q;
    logic          to_d;

    logic [N-1:0]  pend;
    logic [N-1:0]  pend_run;
    logic          clr;
    logic          load;
    logic          run;
    logic          all_done;
    logic          wd_hit;

    assign start_pulse = ap_start & ~ap_start_r_q;
    assign clr         = (state_q == LATCH);
    assign load        = (state_q == START);
    assign run         = (state_q == RUN);
    assign all_done    = ~|pend_run;
    assign wd_hit      = (timeout_cycles_i != '0) &&
                         (wd_q == timeout_cycles_i - CW'(1));

    // Per-channel pending and statistics.
    for (genvar g = 0; g < N; g++) begin : g_chan
        ederah_ctrl_chan_tracker #(
            .C_CNT_WIDTH(CW)
        ) u_trk (
            .clk_i        (data_clk),
            .rst_n_i      (data_rst_n),
            .clr_i        (clr),
            .load_i       (load),
            .en_i         (mask_q[g]),
            .run_i        (run),
            .done_i       (ch_done_i[g]),
            .pending_o    (pend[g]),
            .pending_run_o(pend_run[g]),
            .cycles_o     (ch_cycles_o[g*CW +: CW])
        );
    end

    // State and datapath registers.
    always_ff @(posedge data_clk) begin
        if (!data_rst_n) begin
            state_q      <= IDLE;
            ap_start_r_q <= 1'b0;
            mask_q       <= '0;
            bytes_q      <= '0;
            wd_q         <= '0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ap_start_r_q <= ap_start;
            mask_q       <= mask_d;
            bytes_q      <= bytes_d;
            wd_q         <= wd_d;
            to_q         <= to_d;
        end
    end

    // Next-state: completion has priority over the watchdog.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_pulse) state_d = LATCH;
            LATCH: state_d = START;
            START: state_d = RUN;
            RUN: begin
                if (all_done || wd_hit) begin
                    state_d = DONE;
                end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch sizes, run watchdog, sticky timeout.
    always_comb begin
        mask_d  = mask_q;
        bytes_d = bytes_q;
        wd_d    = wd_q;
        to_d    = to_q;
        if ((state_q == IDLE) && start_pulse) begin
            to_d = 1'b0;
        end
        if (state_q == LATCH) begin
            mask_d = ch_enable_i;
            wd_d   = '0;
            for (int i = 0; i < N; i++) begin
                bytes_d[i*W +: W] = W'(cls_to_bytes(
                    MAX_XFER_W'(xfer_cls_i[i*W +: W])));
            end
        end
        if (state_q == RUN) begin
            if (wd_q != '1) begin
                wd_d = wd_q + CW'(1);
            end
            if (!all_done && wd_hit) begin
                to_d = 1'b1;
            end
        end
    end

    // Outputs decoded from state.
    always_comb begin
        ap_idle    = (state_q == IDLE) || (state_q == DONE);
        ap_done    = (state_q == DONE);
        ch_start_o = (state_q == START) ? mask_q : '0;
    end

    assign ch_xfer_bytes_o = bytes_q;
    assign timeout_o       = to_q;
    assign pending_o       = pend;

endmodule

// File: tb/tb_ederah_kernel_ctrl.sv
// Scoreboard bench for ederah_kernel_ctrl with N=4, 32-bit widths.
// Expected starts/completions are queued; a monitor checks them.
module tb_ederah_kernel_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ap_start;
    logic         ap_idle;
    logic         ap_done;
    logic [3:0]   ch_enable_i;
    logic [127:0] xfer_cls_i;
    logic [31:0]  timeout_cycles_i;
    logic [127:0] ch_xfer_bytes_o;
    logic [3:0]   ch_start_o;
    logic [3:0]   ch_done_i;
    logic         timeout_o;
    logic [3:0]   pending_o;
    logic [127:0] ch_cycles_o;

    typedef struct {
        int           cyc;
        logic         to;
        logic [3:0]   pend;
        logic [127:0] cycv;
        logic [127:0] bytes;
    } exp_done_t;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_start_t;

    exp_done_t  done_q[$];
    exp_start_t start_q[$];

    int cyc = 0;
    int t0  = 0;
    int pass_cnt  = 0;
    int total_cnt = 0;

    ederah_kernel_ctrl #(
        .C_NUM_CHANNELS   (4),
        .C_XFER_SIZE_WIDTH(32),
        .C_CNT_WIDTH      (32)
    ) dut (
        .data_clk        (clk),
        .data_rst_n      (rst_n),
        .ap_start        (ap_start),
        .ap_idle         (ap_idle),
        .ap_done         (ap_done),
        .ch_enable_i     (ch_enable_i),
        .xfer_cls_i      (xfer_cls_i),
        .timeout_cycles_i(timeout_cycles_i),
        .ch_xfer_bytes_o (ch_xfer_bytes_o),
        .ch_start_o      (ch_start_o),
        .ch_done_i       (ch_done_i),
        .timeout_o       (timeout_o),
        .pending_o       (pending_o),
        .ch_cycles_o     (ch_cycles_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] st(logic [127:0] v);
`ifdef EDERAH_CTRL_STATS_EN
        return v;
`else
        return (v & 128'd0);
`endif
    endfunction

    // Monitor: pop and compare whenever the DUT presents an event.
    always @(negedge clk) begin
        exp_done_t  e;
        exp_start_t s;
        if (ap_done) begin
            if (done_q.size() == 0) begin
                chk("spurious_ap_done", 1, 0);
            end else begin
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_timeout", timeout_o, e.to);
                chk("done_pending", pending_o, e.pend);
                chk("done_idle", ap_idle, 1);
                chk("done_bytes", ch_xfer_bytes_o, e.bytes);
                chk("done_cycles", ch_cycles_o, e.cycv);
            end
        end
        if (ch_start_o != 4'h0) begin
            if (start_q.size() == 0) begin
                chk("spurious_start", ch_start_o, 0);
            end else begin
                s = start_q.pop_front();
                chk("start_cycle", cyc, s.cyc);
                chk("start_mask", ch_start_o, s.mask);
            end
        end
    end

    task automatic at(int n);
        while (cyc < t0 + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_run();
        @(posedge clk);
        #1;
        t0 = cyc;
        ap_start = 1'b1;
    endtask

    task automatic pulse_done(int n, logic [3:0] m);
        at(n);
        ch_done_i = m;
        at(n + 1);
        ch_done_i = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n            = 1'b0;
        ap_start         = 1'b0;
        ch_enable_i      = 4'h0;
        xfer_cls_i       = '0;
        timeout_cycles_i = '0;
        ch_done_i        = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_start", ch_start_o, 0);
        chk("rst_bytes", ch_xfer_bytes_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_cycles", ch_cycles_o, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full run, all channels.
        xfer_cls_i  = {32'd4, 32'd3, 32'd2, 32'd1};
        ch_enable_i = 4'hF;
        begin_run();
        start_q.push_back('{t0 + 2, 4'hF});
        done_q.push_back('{t0 + 10, 1'b0, 4'h0,
            st({32'd7, 32'd5, 32'd5, 32'd3}),
            {32'd256, 32'd192, 32'd128, 32'd64}});
        at(1);
        ap_start = 1'b0;
        chk("t1_idle_low", ap_idle, 0);
        pulse_done(5, 4'b0001);
        pulse_done(7, 4'b0110);
        pulse_done(9, 4'b1000);
        at(12);

        // Watchdog timeout with stray dones on masked-off channels.
        xfer_cls_i       = {32'd8, 32'd7, 32'd6, 32'd5};
        ch_enable_i      = 4'b0101;
        timeout_cycles_i = 32'd20;
        begin_run();
        start_q.push_back('{t0 + 2, 4'b0101});
        done_q.push_back('{t0 + 23, 1'b1, 4'b0101,
            st({32'd0, 32'd20, 32'd0, 32'd20}),
            {32'd512, 32'd448, 32'd384, 32'd320}});
        at(1);
        ap_start = 1'b0;
        pulse_done(5, 4'b0010);
        pulse_done(7, 4'b1000);
        at(25);
        chk("t2_timeout_sticky", timeout_o, 1);
        chk("t2_idle_after", ap_idle, 1);

        // Empty mask: immediate completion, timeout flag cleared.
        xfer_cls_i       = {32'd0, 32'd0, 32'd0, 32'd9};
        ch_enable_i      = 4'h0;
        timeout_cycles_i = 32'd0;
        begin_run();
        done_q.push_back('{t0 + 4, 1'b0, 4'h0, 128'd0,
            {32'd0, 32'd0, 32'd0, 32'd576}});
        at(1);
        ap_start = 1'b0;
        chk("t3_timeout_clr", timeout_o, 0);
        at(3);
        chk("t3_idle_c3", ap_idle, 0);
        at(4);
        chk("t3_idle_c4", ap_idle, 1);
        at(6);

        // ap_start held high: exactly one run, then a fresh edge.
        xfer_cls_i  = {32'd0, 32'd0, 32'd0, 32'd1};
        ch_enable_i = 4'b0001;
        begin_run();
        start_q.push_back('{t0 + 2, 4'b0001});
        done_q.push_back('{t0 + 6, 1'b0, 4'h0,
            st({32'd0, 32'd0, 32'd0, 32'd3}),
            {32'd0, 32'd0, 32'd0, 32'd64}});
        pulse_done(5, 4'b0001);
        at(50);
        ap_start = 1'b0;
        at(52);
        chk("t4_held_idle", ap_idle, 1);
        begin_run();
        start_q.push_back('{t0 + 2, 4'b0001});
        done_q.push_back('{t0 + 6, 1'b0, 4'h0,
            st({32'd0, 32'd0, 32'd0, 32'd3}),
            {32'd0, 32'd0, 32'd0, 32'd64}});
        at(1);
        ap_start = 1'b0;
        pulse_done(5, 4'b0001);
        at(8);

        // Size truncation on the shift.
        xfer_cls_i  = {32'd0, 32'hFFFF_FFFF, 32'h0400_0001, 32'h0400_0001};
        ch_enable_i = 4'b0001;
        begin_run();
        start_q.push_back('{t0 + 2, 4'b0001});
        done_q.push_back('{t0 + 7, 1'b0, 4'h0,
            st({32'd0, 32'd0, 32'd0, 32'd4}),
            {32'd0, 32'hFFFF_FFC0, 32'h0000_0040, 32'h0000_0040}});
        at(1);
        ap_start = 1'b0;
        pulse_done(6, 4'b0001);
        at(9);

        // Reset in the middle of a run.
        xfer_cls_i  = {32'd1, 32'd1, 32'd1, 32'd1};
        ch_enable_i = 4'hF;
        begin_run();
        start_q.push_back('{t0 + 2, 4'hF});
        at(1);
        ap_start = 1'b0;
        pulse_done(5, 4'b0001);
        at(6);
        rst_n = 1'b0;
        at(7);
        rst_n = 1'b1;
        chk("t6_idle", ap_idle, 1);
        chk("t6_done", ap_done, 0);
        chk("t6_pending", pending_o, 0);
        chk("t6_bytes", ch_xfer_bytes_o, 0);
        chk("t6_start", ch_start_o, 0);
        pulse_done(8, 4'b1110);
        at(30);
        chk("t6_idle_late", ap_idle, 1);

        chk("done_queue_empty", done_q.size(), 0);
        chk("start_queue_empty", start_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ederah_kernel_ctrl.md
Name: ederah_kernel_ctrl

Overview:
Parametrised kernel control sequencer for multi-channel EDERAH kernels. It turns the SDx ap_start level into one run over C_NUM_CHANNELS independent engine channels. It latches per-channel transfer sizes in cache lines and converts them to bytes, issues per-channel start pulses, and aggregates per-channel done pulses into ap_done/ap_idle. It adds a watchdog timeout and optional per-channel cycle statistics. It sits between the SDx control registers and the channel datamovers (input/output channels).

Parameters:
C_NUM_CHANNELS, 4, number of controlled channels (1..16)
C_XFER_SIZE_WIDTH, 32, width of byte-size outputs and cls inputs
C_CNT_WIDTH, 32, width of timeout and statistics counters

Ports:
data_clk  in  1  sole clock
data_rst_n  in  1  synchronous active-low reset
ap_start  in  1  SDx start level
ap_idle  out  1  high when no run is active
ap_done  out  1  one-cycle pulse at run end
ch_enable_i  in  C_NUM_CHANNELS  channel participation mask, sampled in LATCH
xfer_cls_i  in  C_NUM_CHANNELS*C_XFER_SIZE_WIDTH  per-channel size in 64-byte lines
timeout_cycles_i  in  C_CNT_WIDTH  RUN watchdog limit; 0 disables it
ch_xfer_bytes_o  out  C_NUM_CHANNELS*C_XFER_SIZE_WIDTH  latched cls<<6, stable from START until the next LATCH
ch_start_o  out  C_NUM_CHANNELS  one-cycle start pulse per enabled channel
ch_done_i  in  C_NUM_CHANNELS  per-channel done pulse
timeout_o  out  1  sticky flag: last run ended by watchdog
pending_o  out  C_NUM_CHANNELS  channels not yet done, valid through and after DONE
ch_cycles_o  out  C_NUM_CHANNELS*C_CNT_WIDTH  statistics (see Optional Feature)

Behaviour:
- Reset values: ap_idle=1, ap_done=0, ch_start_o=0, ch_xfer_bytes_o=0, timeout_o=0, pending_o=0, ch_cycles_o=0, state=IDLE, ap_start_r=0.
- Edge detector: ap_start_r <= ap_start every cycle. start_pulse = ap_start & ~ap_start_r.
- start_pulse outside IDLE is ignored. The edge detector still updates, so holding ap_start high never retriggers a run.
- FSM states: IDLE, LATCH, START, RUN, DONE.
- IDLE→LATCH on start_pulse.
  - Pulse cycle = cycle 0.
  - ap_idle goes low in cycle 1.
  - timeout_o clears in cycle 1.
- LATCH (cycle 1):
  - register mask ← ch_enable_i;
  - register ch_xfer_bytes_o[i] ← xfer_cls_i[i] << 6, truncated to C_XFER_SIZE_WIDTH (upper 6 bits dropped, no saturation);
  - clear pending and counters.
- START (cycle 2):
  - ch_start_o = mask for exactly this cycle;
  - pending ← mask.
- RUN (cycle 3 onward):
  - pending[i] clears on ch_done_i[i];
  - done pulses from channels outside mask are ignored;
  - a repeated done on an already-cleared channel is ignored;
  - several channels finishing in the same cycle all clear.
  - Watchdog counter increments each RUN cycle and saturates at its maximum value.
  - RUN→DONE on the cycle after pending becomes 0. Final done in cycle k gives ap_done in cycle k+1.
  - RUN→DONE also when timeout_cycles_i≠0 and watchdog == timeout_cycles_i-1 with pending≠0; timeout_o ← 1. If all channels complete in that same cycle, completion wins and timeout_o stays 0.
- ch_done_i in LATCH/START/IDLE/DONE is ignored. Channels never pulse done before the cycle after their ch_start_o.
- mask==0: RUN sees pending==0 immediately; ap_done is asserted in cycle 4.
- DONE (1 cycle): ap_done=1, ap_idle=1, then IDLE. A start_pulse in the DONE cycle is ignored.
- Reset mid-run: returns to IDLE with reset values next cycle; no ch_start_o or ap_done is emitted.

Optional Feature:
Macro EDERAH_CTRL_STATS_EN.
- Defined:
  - ch_cycles_o[i] counts cycles from START (exclusive) until ch_done_i[i] is accepted (inclusive), saturating;
  - counters for channels still pending at timeout hold their saturated or last value;
  - disabled channels read 0.
- Undefined: ch_cycles_o is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package ederah_ctrl_pkg:
  - typedef enum ctrl_state_t {IDLE, LATCH, START, RUN, DONE};
  - localparam CL_BYTES_LOG2=6;
  - function cls_to_bytes.
- Natural sub-module ederah_ctrl_chan_tracker: one per channel, holding the pending bit and the optional cycle counter; instantiated in a generate loop.

Test Plan:
- N=4, mask=4'b1111, cls={1,2,3,4}; start rises at cycle 0; dones for ch0..3 at cycles 5,7,7,9 → ch_start_o=4'hF at cycle 2; bytes={64,128,192,256}; ap_done at cycle 10; pending_o=0; timeout_o=0; with stats, ch_cycles={3,5,5,7}.
- mask=4'b0101; done pulses on ch1 and ch3 only → run never completes; timeout_cycles_i=20 → ap_done at cycle 23, timeout_o=1, pending_o=4'b0101.
- mask=0 → ch_start_o never asserted; ap_done at cycle 4; ap_idle high from cycle 4.
- ap_start held high for 50 cycles across a completed run → exactly one ap_done; second run only after ap_start falls and rises again.
- cls=32'h0400_0001 → ch_xfer_bytes_o=32'h0000_0040 (truncation).
- Reset asserted in RUN cycle 6 → cycle 7: ap_idle=1, ap_done=0, pending_o=0; later dones are ignored and no spurious ap_done occurs.
